ula_multiciclo: RTL

- Parametrised, registered successor of the single-cycle 8-bit ULA in the uniciclo datapath.
- Adds a start/busy/done handshake, generic WIDTH and a 3-bit ALUOp.
- Adds logic ops, overflow-correct signed compare, and multi-cycle signed multiply and divide.
- Sits between the register file and the write-back mux. The control unit stalls the PC while ocupado=1.

---
 rtl/ula_multiciclo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ula_multiciclo.sv
// Registered ALU with a start/busy/done handshake: ADD/NEG/SUB/SLT/AND/OR in one
// cycle, signed MUL (shift-add) and DIV (restoring) iterating one bit per clock.
module ula_multiciclo #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inicio,
  input  logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] Entrada1,
  input  logic [WIDTH-1:0] Entrada2,
  output logic             ocupado,
  output logic             pronto,
  output logic [WIDTH-1:0] Resultado,
  output logic             Zero,
  output logic             Negativo,
  output logic             Overflow,
  output logic             DivZero
);

  localparam logic [0:0] OCIOSO  = 1'b0;
  localparam logic [0:0] CALCULA = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_NEG = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               is_mul;
  logic               neg_res;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvsr;

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, diff, negated, abs_a, abs_b;
  logic             ovf_add, ovf_sub, slt, b_zero, start_iter;

  assign sum     = Entrada1 + Entrada2;
  assign diff    = Entrada1 - Entrada2;
  assign negated = WIDTH'(0) - Entrada1;
  assign abs_a   = Entrada1[WIDTH-1] ? negated : Entrada1;
  assign abs_b   = Entrada2[WIDTH-1] ? (WIDTH'(0) - Entrada2) : Entrada2;
  assign ovf_add = (Entrada1[WIDTH-1] == Entrada2[WIDTH-1]) &&
                   (sum[WIDTH-1] != Entrada1[WIDTH-1]);
  assign ovf_sub = (Entrada1[WIDTH-1] != Entrada2[WIDTH-1]) &&
                   (diff[WIDTH-1] != Entrada1[WIDTH-1]);
  // Signed less-than stays correct even when A-B overflows.
  assign slt        = diff[WIDTH-1] ^ ovf_sub;
  assign b_zero     = (Entrada2 == '0);
  assign start_iter = (ALUOp == OP_MUL) || ((ALUOp == OP_DIV) && !b_zero);

  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf, sc_dz;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_dz  = 1'b0;
    case (ALUOp)
      OP_ADD: begin sc_res = sum;     sc_ovf = ovf_add; end
      OP_NEG: begin sc_res = negated; sc_ovf = (Entrada1 == MIN_NEG); end
      OP_SUB: begin sc_res = diff;    sc_ovf = ovf_sub; end
      OP_SLT: sc_res = {WIDTH{slt}};
      OP_AND: sc_res = Entrada1 & Entrada2;
      OP_OR:  sc_res = Entrada1 | Entrada2;
      OP_DIV: begin sc_res = '1; sc_dz = 1'b1; end  // only reached with B == 0
      default: ;
    endcase
  end

  // One iteration step on magnitudes, plus the sign fix-up used on the last step
  logic [2*WIDTH-1:0] prod_nx, mul_full;
  logic [WIDTH:0]     rem_sh, trial;
  logic [WIDTH-1:0]   rem_nx, quo_nx, div_res;
  logic [WIDTH:0]     mul_hi;
  logic               take, mul_ovf, div_ovf;

  assign prod_nx  = mplier[0] ? (prod + mcand) : prod;
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, dvsr};
  assign take     = !trial[WIDTH];
  assign rem_nx   = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx   = {quo[WIDTH-2:0], take};

  assign mul_full = neg_res ? ((2*WIDTH)'(0) - prod_nx) : prod_nx;
  assign mul_hi   = mul_full[2*WIDTH-1:WIDTH-1];
  assign mul_ovf  = !((&mul_hi) || !(|mul_hi));
  assign div_res  = neg_res ? (WIDTH'(0) - quo_nx) : quo_nx;
  // Only MIN_NEG / -1 yields a positive quotient with the top bit set.
  assign div_ovf  = !neg_res && quo_nx[WIDTH-1];

  logic             wr_en, wr_ovf, wr_dz;
  logic [WIDTH-1:0] wr_res;

  always_comb begin
    wr_en  = 1'b0;
    wr_res = sc_res;
    wr_ovf = sc_ovf;
    wr_dz  = sc_dz;
    if (state == OCIOSO) begin
      wr_en = inicio && !start_iter;
    end else if (cnt == CNT_W'(1)) begin
      wr_en  = 1'b1;
      wr_res = is_mul ? mul_full[WIDTH-1:0] : div_res;
      wr_ovf = is_mul ? mul_ovf : div_ovf;
      wr_dz  = 1'b0;
    end
  end

  assign ocupado = (state == CALCULA);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= OCIOSO;
      cnt       <= '0;
      is_mul    <= 1'b0;
      neg_res   <= 1'b0;
      mcand     <= '0;
      prod      <= '0;
      mplier    <= '0;
      quo       <= '0;
      rem       <= '0;
      dvsr      <= '0;
      pronto    <= 1'b0;
      Resultado <= '0;
      Zero      <= 1'b0;
      Negativo  <= 1'b0;
      Overflow  <= 1'b0;
      DivZero   <= 1'b0;
    end else begin
      pronto <= wr_en;
      if (wr_en) begin
        Resultado <= wr_res;
        Zero      <= (wr_res == '0);
        Negativo  <= wr_res[WIDTH-1];
        Overflow  <= wr_ovf;
        DivZero   <= wr_dz;
      end
      case (state)
        OCIOSO: begin
          if (inicio && start_iter) begin
            state   <= CALCULA;
            cnt     <= CNT_W'(WIDTH);
            is_mul  <= (ALUOp == OP_MUL);
            neg_res <= Entrada1[WIDTH-1] ^ Entrada2[WIDTH-1];
            mcand   <= {{WIDTH{1'b0}}, abs_a};
            mplier  <= abs_b;
            prod    <= '0;
            quo     <= abs_a;
            rem     <= '0;
            dvsr    <= abs_b;
          end
        end
        default: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          prod   <= prod_nx;
          rem    <= rem_nx;
          quo    <= quo_nx;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= OCIOSO;
        end
      endcase
    end
  end

endmodule
